// File: rtl/stack_unit_pkg.sv
// Shared definitions for the MiniRISC hardware stack engine: FSM states, flag bit
// positions and frame sizes.
package stack_unit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StPushPc,
        StPushFlg,
        StPopFlg,
        StPopPc,
        StDone,
        StWaitLow
    } stack_state_e;

    // Bit positions inside the 6-bit flag vector {IF,IE,V,N,C,Z}
    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_N  = 2;
    localparam int unsigned FLAG_V  = 3;
    localparam int unsigned FLAG_IE = 4;
    localparam int unsigned FLAG_IF = 5;

    localparam logic [7:0] SUB_FRAME = 8'd1;
    localparam logic [7:0] INT_FRAME = 8'd2;

    function automatic logic [7:0] frame_size(input logic is_int);
        return is_int ? INT_FRAME : SUB_FRAME;
    endfunction

endpackage

// File: rtl/stack_unit.sv
// Hardware stack engine: pushes/pops return PC (and flags for interrupt frames) over the
// shared data bus. Define STACK_GUARD_EN to add occupancy checking and the stack_err flag.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter logic [7:0]  SP_INIT     = 8'h00,
    parameter int unsigned STACK_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stack_op_ongoing,
    input  logic       push_or_pop,
    input  logic       int_frame,
    input  logic [7:0] pc_in,
    input  logic [5:0] flags_in,
    output logic       stack_op_end,
    output logic [7:0] return_addr,
    output logic [5:0] flags_out,
    output logic [7:0] SP,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic [7:0] mem_addr,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic [7:0] mem_dout,
    input  logic [7:0] mem_din,
    input  logic       dbg_is_brk,
    input  logic       dbg_sp_wr,
    input  logic [7:0] dbg_data_in
`ifdef STACK_GUARD_EN
    ,
    output logic       stack_err
`endif
);

    stack_state_e state_q;
    logic         push_q;
    logic         int_q;
    logic [7:0]   sp_q;
    logic [7:0]   ret_q;
    logic [5:0]   flags_q;
    logic [7:0]   frame_n;
    logic [7:0]   sp_next;
    logic         reject;

    assign frame_n = frame_size(int_q);
    assign sp_next = push_q ? sp_q - frame_n : sp_q + frame_n;

`ifdef STACK_GUARD_EN
    logic [7:0] occ_q;
    logic       err_q;
    logic [7:0] occ_next;

    assign occ_next = push_q ? occ_q + frame_n : occ_q - frame_n;
    assign reject   = push_q ? (({1'b0, occ_q} + {1'b0, frame_n}) > 9'(STACK_DEPTH))
                             : (occ_q < frame_n);
    assign stack_err = err_q;
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            push_q  <= 1'b0;
            int_q   <= 1'b0;
            sp_q    <= SP_INIT;
            ret_q   <= 8'h00;
            flags_q <= 6'h00;
`ifdef STACK_GUARD_EN
            occ_q   <= 8'h00;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (stack_op_ongoing) begin
                        push_q  <= push_or_pop;
                        int_q   <= int_frame;
                        state_q <= StReq;
                    end else if (dbg_is_brk && dbg_sp_wr) begin
                        sp_q  <= dbg_data_in;
`ifdef STACK_GUARD_EN
                        occ_q <= SP_INIT - dbg_data_in;
`endif
                    end
                end
                StReq: begin
                    if (reject) begin
`ifdef STACK_GUARD_EN
                        err_q <= 1'b1;
`endif
                        state_q <= StDone;
                    end else if (bus_grant) begin
                        if (push_q)     state_q <= StPushPc;
                        else if (int_q) state_q <= StPopFlg;
                        else            state_q <= StPopPc;
                    end
                end
                StPushPc: begin
                    if (int_q) begin
                        state_q <= StPushFlg;
                    end else begin
                        sp_q    <= sp_next;
`ifdef STACK_GUARD_EN
                        occ_q   <= occ_next;
`endif
                        state_q <= StDone;
                    end
                end
                StPushFlg: begin
                    sp_q    <= sp_next;
`ifdef STACK_GUARD_EN
                    occ_q   <= occ_next;
`endif
                    state_q <= StDone;
                end
                StPopFlg: begin
                    flags_q <= mem_din[5:0];
                    state_q <= StPopPc;
                end
                StPopPc: begin
                    ret_q   <= mem_din;
                    sp_q    <= sp_next;
`ifdef STACK_GUARD_EN
                    occ_q   <= occ_next;
`endif
                    state_q <= StDone;
                end
                StDone:    state_q <= StWaitLow;
                // Hold here until the controller drops its request level
                StWaitLow: if (!stack_op_ongoing) state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        mem_addr     = 8'h00;
        mem_dout     = 8'h00;
        stack_op_end = 1'b0;
        case (state_q)
            StReq: bus_req = 1'b1;
            StPushPc: begin
                bus_req  = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = sp_q - 8'd1;
                mem_dout = pc_in;
            end
            StPushFlg: begin
                bus_req  = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = sp_q - 8'd2;
                mem_dout = {2'b00, flags_in};
            end
            StPopFlg: begin
                bus_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = sp_q;
            end
            StPopPc: begin
                bus_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = sp_q + {7'd0, int_q};
            end
            StDone:  stack_op_end = 1'b1;
            default: ;
        endcase
    end

    assign SP          = sp_q;
    assign return_addr = ret_q;
    assign flags_out   = flags_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit; runs the guard scenario when
// STACK_GUARD_EN is defined (DUT then built with STACK_DEPTH = 2).
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stack_op_ongoing, push_or_pop, int_frame;
    logic [7:0] pc_in;
    logic [5:0] flags_in;
    logic       stack_op_end;
    logic [7:0] return_addr;
    logic [5:0] flags_out;
    logic [7:0] SP;
    logic       bus_req, bus_grant;
    logic [7:0] mem_addr, mem_dout, mem_din;
    logic       mem_wr, mem_rd;
    logic       dbg_is_brk, dbg_sp_wr;
    logic [7:0] dbg_data_in;
`ifdef STACK_GUARD_EN
    logic       stack_err;
    localparam int unsigned Depth = 2;
`else
    localparam int unsigned Depth = 32;
`endif

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int end_cnt = 0;
    int wr_base, end_base;

    always #5 clk = ~clk;

    stack_unit #(
        .SP_INIT     (8'h00),
        .STACK_DEPTH (Depth)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stack_op_ongoing (stack_op_ongoing),
        .push_or_pop      (push_or_pop),
        .int_frame        (int_frame),
        .pc_in            (pc_in),
        .flags_in         (flags_in),
        .stack_op_end     (stack_op_end),
        .return_addr      (return_addr),
        .flags_out        (flags_out),
        .SP               (SP),
        .bus_req          (bus_req),
        .bus_grant        (bus_grant),
        .mem_addr         (mem_addr),
        .mem_wr           (mem_wr),
        .mem_rd           (mem_rd),
        .mem_dout         (mem_dout),
        .mem_din          (mem_din),
        .dbg_is_brk       (dbg_is_brk),
        .dbg_sp_wr        (dbg_sp_wr),
        .dbg_data_in      (dbg_data_in)
`ifdef STACK_GUARD_EN
        ,
        .stack_err        (stack_err)
`endif
    );

    // Data memory model: combinational read, write on the clock edge
    assign mem_din = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_dout;

    always @(negedge clk) begin
        if (mem_wr) wr_cnt++;
        if (stack_op_end) end_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_op(input logic push, input logic intf, input logic [7:0] pc,
                            input logic [5:0] flg);
        push_or_pop      = push;
        int_frame        = intf;
        pc_in            = pc;
        flags_in         = flg;
        stack_op_ongoing = 1'b1;
    endtask

    task automatic finish_op();
        stack_op_ongoing = 1'b0;
        tick(2);
    endtask

    // Subroutine push with immediate grant; checks the write and the end pulse
    task automatic call_push(input string tag, input logic [7:0] pc, input logic [7:0] exp_sp);
        start_op(1'b1, 1'b0, pc, 6'h00);
        tick(2);
        check_eq({tag, "_wr"}, {mem_wr, mem_addr, mem_dout}, {1'b1, exp_sp, pc});
        tick();
        check_eq({tag, "_end"}, {stack_op_end, SP}, {1'b1, exp_sp});
        finish_op();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b0;
        stack_op_ongoing = 1'b0;
        push_or_pop = 1'b0;
        int_frame = 1'b0;
        pc_in = 8'h00;
        flags_in = 6'h00;
        bus_grant = 1'b1;
        dbg_is_brk = 1'b0;
        dbg_sp_wr = 1'b0;
        dbg_data_in = 8'h00;
        tick(2);
        check_eq("rst_sp", SP, 8'h00);
        check_eq("rst_regs", {return_addr, flags_out}, 14'h0);
        check_eq("rst_strobes", {bus_req, mem_wr, mem_rd, stack_op_end}, 4'h0);
`ifdef STACK_GUARD_EN
        check_eq("rst_err", stack_err, 1'b0);
`endif
        rst = 1'b1;
        tick();

        // CALL push of 0x42
        start_op(1'b1, 1'b0, 8'h42, 6'h00);
        tick();
        check_eq("call_c1_req", {bus_req, mem_wr}, 2'b10);
        tick();
        check_eq("call_c2_wr", {mem_wr, mem_addr, mem_dout, stack_op_end}, {1'b1, 8'hFF, 8'h42, 1'b0});
        tick();
        check_eq("call_c3_end", {stack_op_end, SP, bus_req}, {1'b1, 8'hFF, 1'b0});
        finish_op();

        // RTS pop
        start_op(1'b0, 1'b0, 8'h00, 6'h00);
        tick(2);
        check_eq("rts_c2_rd", {mem_rd, mem_wr, mem_addr}, {2'b10, 8'hFF});
        tick();
        check_eq("rts_c3_end", {stack_op_end, return_addr, SP}, {1'b1, 8'h42, 8'h00});
        finish_op();

        // Interrupt push, PC 0x10, flags 110101
        start_op(1'b1, 1'b1, 8'h10, 6'b110101);
        tick(2);
        check_eq("int_c2_wr", {mem_wr, mem_addr, mem_dout}, {1'b1, 8'hFF, 8'h10});
        tick();
        check_eq("int_c3_wr", {mem_wr, mem_addr, mem_dout, stack_op_end}, {1'b1, 8'hFE, 8'h35, 1'b0});
        tick();
        check_eq("int_c4_end", {stack_op_end, SP}, {1'b1, 8'hFE});
        finish_op();

        // RTI pop
        start_op(1'b0, 1'b1, 8'h00, 6'h00);
        tick(2);
        check_eq("rti_c2_rd", {mem_rd, mem_addr}, {1'b1, 8'hFE});
        tick();
        check_eq("rti_c3_rd", {mem_rd, mem_addr, flags_out}, {1'b1, 8'hFF, 6'b110101});
        tick();
        check_eq("rti_c4_end", {stack_op_end, return_addr, flags_out, SP},
                 {1'b1, 8'h10, 6'b110101, 8'h00});
        finish_op();

        // Grant withheld for 5 cycles
        bus_grant = 1'b0;
        start_op(1'b1, 1'b0, 8'h77, 6'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("nogrant_hold", {bus_req, mem_wr, mem_rd}, 3'b100);
        end
        bus_grant = 1'b1;
        tick();
        check_eq("grant_wr", {mem_wr, mem_addr, mem_dout}, {1'b1, 8'hFF, 8'h77});
        tick();
        check_eq("grant_end", {stack_op_end, SP}, {1'b1, 8'hFF});
        finish_op();

        // Request held high 3 cycles past the end pulse
        wr_base = wr_cnt;
        end_base = end_cnt;
        start_op(1'b1, 1'b0, 8'h05, 6'h00);
        tick(6);
        stack_op_ongoing = 1'b0;
        tick(4);
        check_eq("hold_wr_cnt", wr_cnt - wr_base, 1);
        check_eq("hold_end_cnt", end_cnt - end_base, 1);
        check_eq("hold_sp_mem", {SP, mem[8'hFE]}, {8'hFE, 8'h05});

        // Debug SP write while halted
        dbg_is_brk = 1'b1;
        dbg_sp_wr = 1'b1;
        dbg_data_in = 8'h80;
        tick();
        dbg_is_brk = 1'b0;
        dbg_sp_wr = 1'b0;
        check_eq("dbg_sp", SP, 8'h80);

        // Reset asserted during PUSH_FLG
        start_op(1'b1, 1'b1, 8'h33, 6'h0A);
        tick(3);
        check_eq("pre_rst_flg", {mem_wr, mem_addr, mem_dout}, {1'b1, 8'h7E, 8'h0A});
        rst = 1'b0;
        stack_op_ongoing = 1'b0;
        #1;
        check_eq("midrst_out", {bus_req, mem_wr, mem_rd, mem_addr, mem_dout, SP}, 27'h0);
        tick();
        rst = 1'b1;
        tick();
        call_push("post_rst", 8'h66, 8'hFF);

`ifdef STACK_GUARD_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        call_push("guard_p1", 8'hA1, 8'hFF);
        call_push("guard_p2", 8'hA2, 8'hFE);
        wr_base = wr_cnt;
        start_op(1'b1, 1'b0, 8'hA3, 6'h00);
        tick(2);
        check_eq("guard_rej_end", {stack_op_end, SP, stack_err}, {1'b1, 8'hFE, 1'b1});
        finish_op();
        check_eq("guard_rej_nowr", wr_cnt - wr_base, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
